// File: rtl/bcd_conv_arbiter.sv
// Shared double-dabble binary-to-BCD converter fronted by an NREQ-way request arbiter.
// Define BCD_CONV_ARB_RR_EN for round-robin grants; otherwise the lowest-index request wins.
module bcd_conv_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     bin_in,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic                      out_valid,
    output logic [4*DIGITS-1:0]       bcd_out,
    output logic [$clog2(NREQ)-1:0]   out_id
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]          state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [4*DIGITS-1:0] acc_shift;
    logic                gnt_any;
    logic [IDW-1:0]      gnt;

`ifdef BCD_CONV_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // Search begins one past the last winner and wraps around.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!gnt_any && req[(int'(ptr) + i) % NREQ]) begin
                gnt_any = 1'b1;
                gnt     = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (state == IDLE && gnt_any) begin
            ptr <= gnt;
        end
    end
`else
    always_comb begin
        gnt_any = |req;
        gnt     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt = IDW'(i);
            end
        end
    end
`endif

    // Add-3 is digit-local; the 4-bit sum never exceeds 12 so nothing carries out.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_sr    <= '0;
            acc       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            out_id    <= '0;
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= gnt_any;
                    if (gnt_any) begin
                        bin_sr   <= bin_in[int'(gnt)*WIDTH +: WIDTH];
                        acc      <= '0;
                        cnt      <= CW'(WIDTH);
                        ack[gnt] <= 1'b1;
                        out_id   <= gnt;
                        state    <= SHIFT;
                    end
                end
                default: begin
                    acc    <= acc_shift;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt - 1'b1;
                    // busy stays high through the out_valid cycle.
                    if (cnt == CW'(1)) begin
                        bcd_out   <= acc_shift;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus random traffic, scored against a
// transaction-level model (decimal arithmetic for results, priority search for grants).
module tb_bcd_conv_arbiter;
    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*WIDTH-1:0]   bin_in = '0;
    logic [NREQ-1:0]         ack;
    logic                    busy;
    logic                    out_valid;
    logic [4*DIGITS-1:0]     bcd_out;
    logic [$clog2(NREQ)-1:0] out_id;

    int total = 0;
    int bad   = 0;

    bcd_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .ack(ack), .busy(busy),
        .out_valid(out_valid), .bcd_out(bcd_out), .out_id(out_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        int start;
`ifdef BCD_CONV_ARB_RR_EN
        start = (last + 1) % NREQ;
`else
        start = 0 * last;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (r[(start + i) % NREQ]) return (start + i) % NREQ;
        end
        return -1;
    endfunction

    // Inputs as seen by the DUT at each rising edge.
    logic                  rst_q = 1'b1;
    logic [NREQ-1:0]       req_q = '0;
    logic [NREQ*WIDTH-1:0] bin_q = '0;
    always @(posedge clk) begin
        rst_q <= rst;
        req_q <= req;
        bin_q <= bin_in;
    end

    // Model: a conversion occupies WIDTH edges after its grant, then the block is free again.
    int              m_left = 0;
    int              m_last = NREQ - 1;
    int              m_val  = 0;
    int              m_id   = 0;
    logic [31:0]     m_bcd  = '0;
    logic [NREQ-1:0] e_ack;
    logic            e_ov;
    int              g;

    always @(negedge clk) begin
        e_ack = '0;
        e_ov  = 1'b0;
        if (rst_q) begin
            m_left = 0;
            m_last = NREQ - 1;
            m_id   = 0;
            m_bcd  = '0;
        end else if (m_left == 0) begin
            if (req_q != '0) begin
                g        = pick(req_q, m_last);
                e_ack[g] = 1'b1;
                m_val    = int'(bin_q[g*WIDTH +: WIDTH]);
                m_id     = g;
                m_last   = g;
                m_left   = WIDTH;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                e_ov  = 1'b1;
                m_bcd = to_bcd(m_val);
            end
        end
        chk("ack", 32'(ack), 32'(e_ack));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("busy", 32'(busy), 32'(m_left != 0 || e_ov));
        chk("bcd_out", 32'(bcd_out), m_bcd);
        chk("out_id", 32'(out_id), 32'(m_id));
    end

    task automatic wait_ack(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[idx] && n < 40);
        chk("ack_seen", 32'(ack[idx]), 32'd1);
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        chk("ov_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic convert(input int idx, input logic [WIDTH-1:0] val, input logic [11:0] exp_bcd);
        @(negedge clk);
        bin_in[idx*WIDTH +: WIDTH] = val;
        req[idx] = 1'b1;
        wait_ack(idx);
        req[idx] = 1'b0;
        bin_in[idx*WIDTH +: WIDTH] = WIDTH'($urandom);
        wait_ov();
        chk("result", 32'(bcd_out), 32'(exp_bcd));
        chk("result_id", 32'(out_id), 32'(idx));
    endtask

    initial begin
        // Reset held with every requester asking.
        rst = 1'b1;
        req = '1;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h000);
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);

        convert(2, 8'd173, 12'h173);
        convert(0, 8'd0,   12'h000);
        convert(1, 8'd255, 12'h255);
        convert(3, 8'd99,  12'h099);
        convert(0, 8'd100, 12'h100);
        repeat (3) @(negedge clk);

        // Contention: everyone holds req.
        bin_in = {8'd40, 8'd30, 8'd20, 8'd10};
        req = '1;
        repeat (46) @(negedge clk);
        req = '0;
        repeat (12) @(negedge clk);

        // Request arriving while busy; operand 0 disturbed mid-flight.
        bin_in[0 +: WIDTH] = 8'd50;
        req[0] = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        bin_in[0 +: WIDTH] = 8'd77;
        repeat (3) @(negedge clk);
        bin_in[WIDTH +: WIDTH] = 8'd61;
        req[1] = 1'b1;
        wait_ov();
        chk("busy_res", 32'(bcd_out), 32'h050);
        wait_ack(1);
        req[1] = 1'b0;
        wait_ov();
        chk("busy_res1", 32'(bcd_out), 32'h061);
        repeat (3) @(negedge clk);

        // Reset in the middle of a conversion.
        bin_in[0 +: WIDTH] = 8'd255;
        req[0] = 1'b1;
        wait_ack(0);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bcd", 32'(bcd_out), 32'h000);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_quiet", 32'(bcd_out), 32'h000);
        convert(0, 8'd42, 12'h042);

        // Random traffic; requesters hold until acked, operands churn every cycle.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            req = req & ~ack;
            if ($urandom_range(0, 2) == 0) req[$urandom_range(0, NREQ-1)] = 1'b1;
            bin_in = (NREQ*WIDTH)'($urandom);
        end
        rst = 1'b0;
        req = '0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shared sequential binary-to-BCD conversion engine with a built-in request arbiter. Up to NREQ requesters post WIDTH-bit binary operands. The block grants one requester at a time and captures its operand. It then runs a shift-and-add-3 (double-dabble) conversion over WIDTH cycles and returns the packed BCD result tagged with the requester index. It sits between the binary producers and the display/decimal consumers, so the design needs only one converter datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, binary operand width
- DIGITS, 3, BCD digits in the result; the integrator must guarantee 10^DIGITS > 2^WIDTH-1
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester level request; hold high until the matching ack
- bin_in  in  NREQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot, one-cycle pulse; operand of that requester was captured
- busy  out  1  high while a conversion is in progress
- out_valid  out  1  one-cycle pulse; bcd_out/out_id hold a new result
- bcd_out  out  4*DIGITS  packed BCD, digit k at [4k+3:4k], digit 0 = units
- out_id  out  $clog2(NREQ)  index of the requester that owns bcd_out

## Operation
- State machine with two states: IDLE and SHIFT.
- **IDLE**
  - If any req bit is high, select the grant g and capture bin_in slice g into the binary shift register.
  - Clear the BCD accumulator, load the bit counter with WIDTH, register ack[g]=1 and out_id<=g, and move to SHIFT.
  - If req is zero, stay in IDLE.
- **SHIFT**
  - Each cycle: every accumulator digit >= 5 gets +3, then {accumulator, binary} shifts left by one and the counter decrements.
  - On the shift that brings the counter to 0:
    - load bcd_out with the post-shift accumulator,
    - pulse out_valid,
    - return to IDLE.
- Digit add-3 arithmetic is 4-bit per digit. No carry crosses digits before the shift.
- The operand is sampled only at the grant edge. Later changes on bin_in do not affect the conversion in flight.
- Requests that arrive while busy wait; they are not acked until the block returns to IDLE.
- Transfer handshake:
  - A transfer is the rising edge at which the grant is taken.
  - ack is visible in the following cycle.
  - A requester that still holds req high after its ack is treated as a new request.
- bcd_out and out_id hold their last values until the next completion.
- Reset values:
  - state IDLE, counter 0;
  - ack, busy, out_valid, bcd_out, out_id all 0;
  - arbitration pointer = NREQ-1, so requester 0 wins the first round-robin decision.
- Reset mid-conversion aborts the conversion: no out_valid, no bcd_out update, no ack pending.

## Timing
- Let edge E0 be the grant edge.
  - ack[g] is high in cycle E0..E1.
  - busy is high from E0 through E(WIDTH).
  - out_valid is high in cycle E(WIDTH)..E(WIDTH+1).
- Latency: ack to out_valid = WIDTH cycles (8 at the default).
- Earliest next grant is edge E(WIDTH+1), so throughput is one conversion per WIDTH+1 cycles.
- out_valid and the next ack may be high in the same cycle only if a new grant occurs at E(WIDTH+1). They never coincide with the same conversion's ack.
- Single-bit req changes take effect at the next IDLE edge. There is no combinational path from req to ack.

## Configuration
- BCD_CONV_ARB_RR_EN defined: round-robin arbitration.
  - The search starts at (last grant + 1) mod NREQ.
  - The pointer updates only on a grant.
- Not defined: fixed priority. The lowest-index active req always wins, and the pointer register is not built.

## Test plan
- **Reset.** Assert rst for 2 cycles with req=4'b1111 → ack=0, busy=0, out_valid=0, bcd_out=12'h000, out_id=0; no ack until rst drops.
- **Single conversion.** req=4'b0100, operand 2 = 8'd173 → ack=4'b0100 for one cycle; out_valid 8 cycles later with bcd_out=12'h173, out_id=2; busy high for 9 cycles total.
- **Boundaries.** Operand 8'd0 → 12'h000; 8'd255 → 12'h255; 8'd99 → 12'h099; 8'd100 → 12'h100.
- **Contention.** req=4'b1111 held, operands 10/20/30/40 → with BCD_CONV_ARB_RR_EN:
  - out_id sequence 0,1,2,3,0;
  - results 12'h010, 12'h020, 12'h030, 12'h040;
  - consecutive grants exactly 9 cycles apart.
  - Without the macro, every grant goes to requester 0.
- **Request while busy.** req[1] rises 3 cycles after ack[0] → ack[1] occurs exactly one cycle after out_valid for requester 0 (E9 grant). bin_in[0] changes after E0 must not alter requester 0's result.
- **Reset mid-conversion.** rst asserted 4 cycles after grant of 8'd255 → no out_valid; bcd_out=12'h000; busy=0. The next request converts correctly.
